// File: rtl/axis_seg_translator_if.sv
// AXI-stream channel bundle used by the segment translator (one per direction).
// Latency: none, wiring only. Backpressure: tready flows from slave to master.
// Ports: tdata[W-1:0], tvalid (master -> slave), tready (slave -> master).
interface axis_seg_translator_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_seg_translator.sv
// Two-channel (rd/wr) virtual->physical translator with a programmable segment table.
// Latency: 1 cycle from input accept to registered output; 1 result/cycle per channel.
// Backpressure: in_tready = ~out_tvalid | out_tready, so the output register never overflows.
// Ports: clk, reset (async, active-high); axis_ird/axis_iwr slave {meta, vaddr};
//        axis_ord/axis_owr master {fault, paddr}; cfg_* table write port;
//        stat_clr and four saturating counters (accepts and faults per channel).
module axis_seg_translator #(
  parameter int          ADDR_W       = 32,
  parameter int          META_W       = 11,
  parameter int          SEG_BITS     = 5,
  parameter logic [31:0] RESET_STRIDE = 32'h1000,
  parameter int          STAT_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  axis_seg_translator_if.slave         axis_ird,
  axis_seg_translator_if.slave         axis_iwr,
  axis_seg_translator_if.master        axis_ord,
  axis_seg_translator_if.master        axis_owr,
  input  logic                         cfg_wr_en,
  input  logic [SEG_BITS-1:0]          cfg_idx,
  input  logic [ADDR_W-1:0]            cfg_base,
  input  logic [ADDR_W-SEG_BITS-1:0]   cfg_limit,
  input  logic                         cfg_valid,
  input  logic                         stat_clr,
  output logic [STAT_W-1:0]            stat_rd_cnt,
  output logic [STAT_W-1:0]            stat_wr_cnt,
  output logic [STAT_W-1:0]            stat_rd_flt,
  output logic [STAT_W-1:0]            stat_wr_flt
);
  localparam int OFF_W = ADDR_W - SEG_BITS;
  localparam int DEPTH = 1 << SEG_BITS;
  localparam int IN_W  = META_W + ADDR_W;
  localparam int OUT_W = ADDR_W + 1;

  function automatic logic [ADDR_W-1:0] reset_base(int i);
    logic [63:0] prod;
    prod = 64'(i) * 64'(RESET_STRIDE);
    return prod[ADDR_W-1:0];
  endfunction

  // Segment table
  logic [ADDR_W-1:0] base_q  [DEPTH];
  logic [OFF_W-1:0]  limit_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  // Writes land at the edge, so a same-cycle lookup still sees the old entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        base_q[i]  <= reset_base(i);
        limit_q[i] <= '1;
      end
      valid_q <= '1;
    end else if (cfg_wr_en) begin
      base_q[cfg_idx]  <= cfg_base;
      limit_q[cfg_idx] <= cfg_limit;
      valid_q[cfg_idx] <= cfg_valid;
    end
  end

  // Metadata rides along on the input but is intentionally dropped.
  logic unused_meta;
  assign unused_meta = ^{axis_ird.tdata[IN_W-1:ADDR_W], axis_iwr.tdata[IN_W-1:ADDR_W]};

  // Read channel lookup
  logic [ADDR_W-1:0]   rd_vaddr, rd_paddr;
  logic [SEG_BITS-1:0] rd_seg;
  logic [OFF_W-1:0]    rd_off;
  logic                rd_flt;

  assign rd_vaddr = axis_ird.tdata[ADDR_W-1:0];
  assign rd_seg   = rd_vaddr[ADDR_W-1 -: SEG_BITS];
  assign rd_off   = rd_vaddr[OFF_W-1:0];
  assign rd_flt   = ~valid_q[rd_seg] | (rd_off > limit_q[rd_seg]);
  assign rd_paddr = rd_flt ? '0 : base_q[rd_seg] + ADDR_W'(rd_off);

  // Write channel lookup
  logic [ADDR_W-1:0]   wr_vaddr, wr_paddr;
  logic [SEG_BITS-1:0] wr_seg;
  logic [OFF_W-1:0]    wr_off;
  logic                wr_flt;

  assign wr_vaddr = axis_iwr.tdata[ADDR_W-1:0];
  assign wr_seg   = wr_vaddr[ADDR_W-1 -: SEG_BITS];
  assign wr_off   = wr_vaddr[OFF_W-1:0];
  assign wr_flt   = ~valid_q[wr_seg] | (wr_off > limit_q[wr_seg]);
  assign wr_paddr = wr_flt ? '0 : base_q[wr_seg] + ADDR_W'(wr_off);

  // Handshake: the input may advance whenever the output slot is empty or draining.
  logic rd_rdy, wr_rdy, rd_acc, wr_acc;
  logic ord_vld, owr_vld;
  logic [OUT_W-1:0] ord_dat, owr_dat;

  assign rd_rdy = ~ord_vld | axis_ord.tready;
  assign wr_rdy = ~owr_vld | axis_owr.tready;
  assign rd_acc = axis_ird.tvalid & rd_rdy;
  assign wr_acc = axis_iwr.tvalid & wr_rdy;

  assign axis_ird.tready = rd_rdy;
  assign axis_iwr.tready = wr_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ord_vld <= 1'b0;
      ord_dat <= '0;
    end else if (rd_acc) begin
      ord_vld <= 1'b1;
      ord_dat <= {rd_flt, rd_paddr};
    end else if (axis_ord.tready) begin
      ord_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owr_vld <= 1'b0;
      owr_dat <= '0;
    end else if (wr_acc) begin
      owr_vld <= 1'b1;
      owr_dat <= {wr_flt, wr_paddr};
    end else if (axis_owr.tready) begin
      owr_vld <= 1'b0;
    end
  end

  assign axis_ord.tvalid = ord_vld;
  assign axis_ord.tdata  = ord_dat;
  assign axis_owr.tvalid = owr_vld;
  assign axis_owr.tdata  = owr_dat;

  // Statistics: [0] rd accepts, [1] wr accepts, [2] rd faults, [3] wr faults.
  logic [STAT_W-1:0] stat_q [4];
  logic [3:0]        stat_inc;

  assign stat_inc = {wr_acc & wr_flt, rd_acc & rd_flt, wr_acc, rd_acc};

  // Clear beats a same-cycle increment; counters stick at all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) stat_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (stat_clr)
          stat_q[k] <= '0;
        else if (stat_inc[k] && (stat_q[k] != '1))
          stat_q[k] <= stat_q[k] + STAT_W'(1);
      end
    end
  end

  assign stat_rd_cnt = stat_q[0];
  assign stat_wr_cnt = stat_q[1];
  assign stat_rd_flt = stat_q[2];
  assign stat_wr_flt = stat_q[3];
endmodule
